// File: rtl/time_of_day_pkg.sv
// rtl/time_of_day_pkg.sv - shared constants, types and helpers for the time-of-day clock
package time_of_day_pkg;

    localparam int CLK_DIV_DEFAULT = 50000000;

    // Packed BCD field: [7:4] tens digit, [3:0] units digit
    typedef logic [7:0] bcd8_t;

    localparam bcd8_t HOUR_MAX = 8'h23;
    localparam bcd8_t MIN_MAX  = 8'h59;
    localparam bcd8_t SEC_MAX  = 8'h59;

    // A preset field is legal when both digits are decimal and the value does not
    // exceed the field limit; with decimal digits a plain compare orders BCD correctly.
    function automatic logic bcd_field_valid(input bcd8_t value, input bcd8_t limit);
        return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= limit);
    endfunction

endpackage

// File: rtl/time_of_day_if.sv
// rtl/time_of_day_if.sv - control, preset and time/pulse signals of the time-of-day clock
interface time_of_day_if;
    import time_of_day_pkg::*;

    logic  En;
    logic  load;
    bcd8_t set_hour;
    bcd8_t set_min;
    bcd8_t set_sec;
    bcd8_t hour;
    bcd8_t minute;
    bcd8_t second;
    logic  sec_cp;
    logic  day_cp;
    logic  load_err;

    modport master (
        output En, load, set_hour, set_min, set_sec,
        input  hour, minute, second, sec_cp, day_cp, load_err
    );

    modport slave (
        input  En, load, set_hour, set_min, set_sec,
        output hour, minute, second, sec_cp, day_cp, load_err
    );

endinterface

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit packed-BCD modulo counter with load and carry-out
module bcd_mod_counter
    import time_of_day_pkg::*;
#(
    parameter bcd8_t MAX = 8'h59
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  inc_i,
    input  logic  load_i,
    input  bcd8_t load_val_i,
    output bcd8_t count_o,
    output logic  carry_o
);

    bcd8_t count_q;
    bcd8_t count_d;

    // Next value: load beats increment; increment wraps at MAX, units 9 rolls into tens
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (inc_i) begin
            if (count_q == MAX) begin
                count_d = 8'h00;
            end else if (count_q[3:0] == 4'd9) begin
                count_d = {count_q[7:4] + 4'd1, 4'd0};
            end else begin
                count_d = {count_q[7:4], count_q[3:0] + 4'd1};
            end
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= 8'h00;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign carry_o = inc_i && (count_q == MAX);

endmodule

// File: rtl/time_of_day.sv
// rtl/time_of_day.sv - BCD hh:mm:ss clock with prescaler, validated preset and day pulse
module time_of_day
    import time_of_day_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic         cp,
    input  logic         CR,
    time_of_day_if.slave bus
);

    localparam int             PW     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]  PS_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] ps_q, ps_d;
    logic          sec_cp_q, sec_cp_d;
    logic          day_cp_q, day_cp_d;
    logic          load_err_q, load_err_d;

    logic  tick;
    logic  load_ok;
    logic  advance;
    logic  sec_carry, min_carry, hour_carry;
    bcd8_t sec_val, min_val, hour_val;

    assign load_ok = bus.load
                   && bcd_field_valid(bus.set_hour, HOUR_MAX)
                   && bcd_field_valid(bus.set_min,  MIN_MAX)
                   && bcd_field_valid(bus.set_sec,  SEC_MAX);

    // A strobe of load, legal or not, swallows a coincident tick
    assign tick    = bus.En && (ps_q == PS_MAX);
    assign advance = tick && !bus.load;

    // Prescaler and pulse next-state; a legal load restarts the second
    always_comb begin
        ps_d       = ps_q;
        sec_cp_d   = advance;
        day_cp_d   = hour_carry;
        load_err_d = bus.load && !load_ok;
        if (load_ok) begin
            ps_d = '0;
        end else if (bus.En && !bus.load) begin
            ps_d = (ps_q == PS_MAX) ? '0 : ps_q + PW'(1);
        end
    end

    // Prescaler and pulse registers; CR overrides everything including a pending tick
    always_ff @(posedge cp) begin
        if (CR) begin
            ps_q       <= '0;
            sec_cp_q   <= 1'b0;
            day_cp_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            ps_q       <= ps_d;
            sec_cp_q   <= sec_cp_d;
            day_cp_q   <= day_cp_d;
            load_err_q <= load_err_d;
        end
    end

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clk_i      (cp),
        .rst_i      (CR),
        .inc_i      (advance),
        .load_i     (load_ok),
        .load_val_i (bus.set_sec),
        .count_o    (sec_val),
        .carry_o    (sec_carry)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .clk_i      (cp),
        .rst_i      (CR),
        .inc_i      (sec_carry),
        .load_i     (load_ok),
        .load_val_i (bus.set_min),
        .count_o    (min_val),
        .carry_o    (min_carry)
    );

    bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
        .clk_i      (cp),
        .rst_i      (CR),
        .inc_i      (min_carry),
        .load_i     (load_ok),
        .load_val_i (bus.set_hour),
        .count_o    (hour_val),
        .carry_o    (hour_carry)
    );

    assign bus.second   = sec_val;
    assign bus.minute   = min_val;
    assign bus.hour     = hour_val;
    assign bus.sec_cp   = sec_cp_q;
    assign bus.day_cp   = day_cp_q;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_time_of_day.sv
// tb/tb_time_of_day.sv - directed self-checking bench for time_of_day with CLK_DIV=4
module tb_time_of_day;

    logic cp;
    logic CR;
    int   errors;
    int   checks;

    time_of_day_if tif ();

    time_of_day #(.CLK_DIV(4)) dut (
        .cp  (cp),
        .CR  (CR),
        .bus (tif)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    task automatic step(input int n);
        repeat (n) @(posedge cp);
        #1;
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input logic [23:0] exp);
        chk(tag, {tif.hour, tif.minute, tif.second}, exp);
    endtask

    task automatic chk_pulses(input string tag, input logic sec_exp, input logic day_exp);
        chk(tag, {21'd0, tif.sec_cp, tif.day_cp, tif.load_err}, {21'd0, sec_exp, day_exp, 1'b0});
    endtask

    task automatic drive_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        tif.set_hour = h;
        tif.set_min  = m;
        tif.set_sec  = s;
        tif.load     = 1'b1;
        step(1);
        tif.load     = 1'b0;
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        CR           = 1'b1;
        tif.En       = 1'b1;
        tif.load     = 1'b0;
        tif.set_hour = 8'h00;
        tif.set_min  = 8'h00;
        tif.set_sec  = 8'h00;

        // Reset state
        step(2);
        chk_time("reset_time", 24'h000000);
        chk_pulses("reset_pulses", 1'b0, 1'b0);

        // Free run: sec_cp on every 4th cycle, second reaches 04 after 16 cycles
        CR = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step(1);
            chk_pulses($sformatf("run_pulse_%0d", i), (i % 4) == 0, 1'b0);
        end
        chk_time("run_16", 24'h000004);

        // Day wrap from a preset 23:59:58
        drive_load(8'h23, 8'h59, 8'h58);
        chk_time("load_235958", 24'h235958);
        chk_pulses("load_235958_pulses", 1'b0, 1'b0);
        step(3);
        chk_time("hold_235958", 24'h235958);
        step(1);
        chk_time("tick_235959", 24'h235959);
        chk_pulses("tick_235959_pulses", 1'b1, 1'b0);
        step(3);
        chk_pulses("hold_235959_pulses", 1'b0, 1'b0);
        step(1);
        chk_time("wrap_000000", 24'h000000);
        chk_pulses("wrap_pulses", 1'b1, 1'b1);
        step(1);
        chk_pulses("after_wrap_pulses", 1'b0, 1'b0);

        // Rejected presets with counting paused
        tif.En = 1'b0;
        drive_load(8'h12, 8'h60, 8'h00);
        chk("err_min60", {23'd0, tif.load_err}, 24'd1);
        chk_time("err_min60_time", 24'h000000);
        step(1);
        chk("err_min60_clear", {23'd0, tif.load_err}, 24'd0);
        drive_load(8'h24, 8'h00, 8'h00);
        chk("err_hour24", {23'd0, tif.load_err}, 24'd1);
        chk_time("err_hour24_time", 24'h000000);
        step(1);
        drive_load(8'h1A, 8'h00, 8'h00);
        chk("err_digitA", {23'd0, tif.load_err}, 24'd1);
        chk_time("err_digitA_time", 24'h000000);
        step(1);
        chk("err_digitA_clear", {23'd0, tif.load_err}, 24'd0);

        // Load accepted while paused, then load collides with a tick
        drive_load(8'h10, 8'h00, 8'h03);
        chk_time("load_100003", 24'h100003);
        tif.En = 1'b1;
        step(3);
        chk_time("pre_collide", 24'h100003);
        drive_load(8'h05, 8'h06, 8'h07);
        chk_time("collide_time", 24'h050607);
        chk_pulses("collide_pulses", 1'b0, 1'b0);
        step(3);
        chk_time("collide_hold", 24'h050607);
        chk_pulses("collide_hold_pulses", 1'b0, 1'b0);
        step(1);
        chk_time("collide_next", 24'h050608);
        chk_pulses("collide_next_pulses", 1'b1, 1'b0);

        // Pause at 00:00:59 with the prescaler part-way through
        drive_load(8'h00, 8'h00, 8'h59);
        step(2);
        tif.En = 1'b0;
        step(10);
        chk_time("pause_time", 24'h000059);
        chk_pulses("pause_pulses", 1'b0, 1'b0);
        tif.En = 1'b1;
        step(1);
        chk_time("resume_1", 24'h000059);
        step(1);
        chk_time("resume_2", 24'h000100);
        chk_pulses("resume_2_pulses", 1'b1, 1'b0);

        // Reset in the tick cycle at 23:59:59
        drive_load(8'h23, 8'h59, 8'h59);
        step(3);
        CR = 1'b1;
        step(1);
        chk_time("cr_tick_time", 24'h000000);
        chk_pulses("cr_tick_pulses", 1'b0, 1'b0);
        CR = 1'b0;
        step(1);
        chk_pulses("cr_after_pulses", 1'b0, 1'b0);
        step(2);
        chk_time("cr_ps_3", 24'h000000);
        step(1);
        chk_time("cr_ps_tick", 24'h000001);
        chk_pulses("cr_ps_tick_pulses", 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
